// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, valid/ready handshake on both sides.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [W2-1:0]     iter;
  logic [W2-1:0]     prod;
  logic [XLEN-1:0]   quo_rem;
  logic [XLEN-1:0]   final_res;

  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              div_by_zero, div_ovf;

  // One datapath step; acc holds {partial, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, b_mag_q}) : div_shift[XLEN-1:0];
    iter      = op_q[2] ? {div_rem, acc_q[XLEN-2:0], div_ge}
                        : {mul_sum, acc_q[XLEN-1:1]};
    prod      = neg_q ? -iter : iter;
    quo_rem   = op_q[1] ? iter[W2-1:XLEN] : iter[XLEN-1:0];
    if (op_q[2]) begin
      final_res = neg_q ? -quo_rem : quo_rem;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    end
  end

  // Operand sign/magnitude and special-case decode at the accept edge.
  always_comb begin
    a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sign_a      = a_signed & src_a[XLEN-1];
    sign_b      = b_signed & src_b[XLEN-1];
    a_mag_in    = sign_a ? -src_a : src_a;
    b_mag_in    = sign_b ? -src_b : src_b;
    div_by_zero = op[2] && (src_b == '0);
    div_ovf     = op[2] && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = op;
            neg_d   = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
            a_mag_d = a_mag_in;
            b_mag_d = b_mag_in;
            cnt_d   = '0;
            acc_d   = op[2] ? {{XLEN{1'b0}}, a_mag_in} : {{XLEN{1'b0}}, b_mag_in};
            if (div_by_zero) begin
              state_d  = S_DONE;
              result_d = op[1] ? src_a : {XLEN{1'b1}};
            end else if (div_ovf) begin
              state_d  = S_DONE;
              result_d = op[1] ? {XLEN{1'b0}} : src_a;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_d = iter;
          if (cnt_q != CNT_W'(XLEN)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d  = S_DONE;
            result_d = final_res;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, result;
  logic        in_ready, out_valid, busy;

  logic        in_valid8, out_ready8, in_ready8, out_valid8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .src_a(a8), .src_b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    qa = $signed(a);
    qb = $signed(b);
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(qa / qb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(qa % qb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, wait for the result, optionally stall in DONE, then consume it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    int lat, exp_lat;
    bit rdy_seen;
    exp     = ref_result(o, a, b);
    exp_lat = is_special(o, a, b) ? 0 : 32;
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 3'($urandom);
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 64) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("in_ready_while_busy", {31'h0, rdy_seen}, 32'h0);
    chk($sformatf("result op%0d %h,%h", o, a, b), result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1;
      chk("hold_result", result, exp);
      chk("hold_flags", {29'h0, out_valid, in_ready, busy}, 32'b101);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_take", {29'h0, out_valid, in_ready, busy}, 32'b010);
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  int          lat8;
  bit          ov_seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {29'h0, out_valid, in_ready, busy}, 32'b010);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'hFFFF_FFF0, 32'd3, 5);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd19, 0);

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'h0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 15));
        3: r_a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(r_op, r_a, r_b, (i % 10 == 0) ? 2 : 0);
    end

    // Flush on RUN cycle 10.
    @(negedge clk);
    op = 3'd0; src_a = 32'd123; src_b = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_run_flags", {29'h0, out_valid, in_ready, busy}, 32'b010);
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      ov_seen |= out_valid;
    end
    chk("flush_no_result", {31'h0, ov_seen}, 32'h0);

    // Flush coincident with a request in IDLE.
    @(negedge clk);
    op = 3'd5; src_a = 32'd9; src_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_reject", {29'h0, out_valid, in_ready, busy}, 32'b010);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chk("flush_idle_still_idle", {29'h0, out_valid, in_ready, busy}, 32'b010);

    // Reset mid-RUN.
    @(negedge clk);
    op = 3'd1; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_flags", {29'h0, out_valid, in_ready, busy}, 32'b010);
    chk("rst_run_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd6, 32'hFFFF_FF00, 32'd7, 0);

    // 8-bit instance: DIVU 200/3.
    @(negedge clk);
    op8 = 3'd5; a8 = 8'd200; b8 = 8'd3; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat8 = 0;
    while (!out_valid8 && lat8 < 32) begin
      @(posedge clk); #1;
      lat8++;
    end
    chk("x8_latency", 32'(lat8), 32'd8);
    chk("x8_divu", {24'h0, result8}, 32'd66);
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("x8_idle", {29'h0, out_valid8, in_ready8, busy8}, 32'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in data width.
- Sits beside the single-cycle ALU in the core datapath. It is selected when opcode 51 has funct7 = 0000001.
- Executes all eight M-extension operations with a valid/ready handshake on input and output, so the core stalls pc update while the unit is busy.
- Computes one result bit per cycle using shift-add for multiply and restoring division for divide.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, even).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
flush  input  1  abort in-flight operation (synchronous)
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  XLEN  rs1 value
src_b  input  XLEN  rs2 value
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  operation result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: the following values apply on any rising edge with rst=1, overriding everything.
  - state=IDLE.
  - out_valid=0, result=0, busy=0, in_ready=1.
  - Internal accumulators and counter are cleared.
- States are IDLE, RUN and DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE).
- Accept condition is in_valid && in_ready && !flush. On an accepting edge:
  - latch op, src_a and src_b;
  - latch operand signs;
  - latch absolute-value magnitudes. Signed operands are rs1 for MULH/MULHSU/DIV/REM and rs2 for MULH/DIV/REM.
- Special cases, detected at accept, go IDLE->DONE directly (result valid 1 cycle after accept):
  - DIV/DIVU with src_b==0: result = all ones.
  - REM/REMU with src_b==0: result = src_a.
  - DIV with src_a = 1<<(XLEN-1) and src_b = all ones: result = src_a.
  - REM with src_a = 1<<(XLEN-1) and src_b = all ones: result = 0.
- Otherwise IDLE->RUN with counter=0.
- RUN performs one iteration per edge and increments the counter. On the edge where the counter reaches XLEN, go to DONE with the final result registered.
  - Net effect: out_valid is first seen exactly XLEN cycles after the accept edge.
- Multiply:
  - Form an unsigned 2*XLEN magnitude product.
  - Negate it (two's complement, 2*XLEN bits) if the product sign is negative.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide:
  - Unsigned restoring division of the magnitudes.
  - Quotient is negated if operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - Division truncates toward zero.
- DONE holds result stable until the edge with out_ready=1, then goes to IDLE.
  - A new request can be accepted no earlier than the next cycle (no same-cycle turnaround).
- Operand inputs are ignored outside the accept edge; changes during RUN do not affect the result.
- flush=1 on any edge:
  - state->IDLE, out_valid drops, no result is delivered;
  - a coincident in_valid is not accepted;
  - result register keeps its old value (don't-care).
- rst has priority over flush; flush has priority over the accept and DONE handshakes.
- Counter never wraps: it saturates at XLEN and is cleared on accept.

Test Plan:
- XLEN=32, MUL src_a=7, src_b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid first high exactly 32 cycles after accept edge; in_ready low throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x10000 x 0x10000 -> 0x00000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
  - REM of the same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - result is stable, in_ready=0, and a new in_valid is ignored;
  - out_ready=1 -> IDLE next edge, in_ready=1;
  - a back-to-back request is accepted the following cycle.
- Abort paths:
  - flush on RUN cycle 10 -> IDLE next edge, out_valid never asserts;
  - flush with in_valid in IDLE -> not accepted;
  - rst mid-RUN -> all outputs return to reset values next edge;
  - XLEN=8 DIVU 200/3 -> 66 after 8 cycles.
